reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
Parametrised multi-port integer register file, the next generation of the core's single-write, dual-read register file. It supports NREAD combinational read ports, NWRITE prioritised write ports, and optional write-to-read bypass. A per-register busy scoreboard is set at issue and cleared at writeback. It sits between decode/issue (reads, alloc) and writeback (writes) in the RV64 pipeline.

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers; register 0 hardwired to zero
NREAD, 2, number of read ports
NWRITE, 2, number of write ports; higher index has priority
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value
(localparam AW = $clog2(NREGS))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
rd_addr  in  NREAD*AW  read addresses, port p at [p*AW +: AW]
rd_data  out  NREAD*XLEN  read data, port p at [p*XLEN +: XLEN]
rd_busy  out  NREAD  scoreboard bit of addressed register, per port
wr_en  in  NWRITE  write enables
wr_addr  in  NWRITE*AW  write addresses
wr_data  in  NWRITE*XLEN  write data
alloc_en  in  1  mark alloc_addr busy (instruction issued with this destination)
alloc_addr  in  AW  destination register being allocated
busy_vec  out  NREGS  full scoreboard, bit r = register r pending
conflict  out  1  registered flag: previous cycle had two enabled write ports to the same nonzero address

Behaviour:
- Reset (async, active-high): all registers 0, busy_vec 0, conflict 0. While reset is high, writes and allocs are ignored, bypass is suppressed, rd_data = 0, and rd_busy = 0.
- Register 0: never written, never busy. Reads of address 0 return 0 and rd_busy 0 regardless of writes or bypass.
- Write: on the rising clk, for each register r != 0, the highest-index port w with wr_en[w] and wr_addr[w]==r writes wr_data[w]. Lower-index ports to the same r are dropped.
- Conflict: conflict <= 1 on the edge after any cycle with two or more enabled ports sharing a nonzero address; otherwise 0. Address 0 collisions do not flag.
- Read: combinational, zero latency.
  - BYPASS=1: if any enabled write port matches the nonzero rd_addr, rd_data is that port's wr_data, using the same priority as the write.
  - BYPASS=0 or no match: rd_data is the stored value.
- Scoreboard, per register r != 0, each edge:
  - alloc_en && alloc_addr==r: busy[r] <= 1. Alloc wins over a same-cycle writeback, because it is a new producer.
  - else any enabled write to r: busy[r] <= 0.
  - else busy[r] holds.
- rd_busy[p] = busy[rd_addr[p]] & ~(BYPASS & same-cycle enabled write to that nonzero address). Same-cycle alloc does not affect rd_busy, since alloc is visible from the next cycle.
- Writes to a register that is not busy are legal; the data is stored and busy stays 0.
- Out-of-range addresses (>= NREGS when NREGS is not a power of 2): reads return 0 with busy 0; writes and allocs are ignored.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Decomposition:
- Shared package/include (rf_pkg): XLEN default, NREGS default, AW derivation, and the REG_ZERO constant.
- One natural sub-module, rf_wr_select: priority match of NWRITE ports against one address, returning hit, data and multi-hit. It is instantiated per register for writes and per read port for bypass. Scoreboard logic stays inline.

Test Plan:
- Reset then read all addresses on both ports -> rd_data=0, rd_busy=0, busy_vec=0, conflict=0.
- wr_en=2'b01, port0 x5=0xDEAD_BEEF; next cycle read x5 -> 0xDEAD_BEEF. Same cycle with BYPASS=1 -> rd_data already 0xDEAD_BEEF; with BYPASS=0 -> old value 0.
- Both ports write x7 (port0 0x1111, port1 0x2222) -> x7=0x2222, conflict=1 the following cycle only. Both ports write x0 -> x0 reads 0, conflict stays 0.
- alloc x9 -> busy_vec[9]=1 next cycle and rd_busy=1 on reads of x9. Then write x9 -> rd_busy=0 in the write cycle (BYPASS=1), busy_vec[9]=0 after the edge.
- alloc x9 and write x9 in the same cycle -> busy_vec[9] remains 1 and x9 takes the new data.
- Write x3=0x55 and alloc x4, then assert reset asynchronously between edges -> outputs go to 0 immediately, x3 reads 0 after release, and busy_vec=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port integer register file.
//   XLEN_DEF  - default register width
//   NREGS_DEF - default number of architectural registers
//   REG_ZERO  - index of the hardwired-zero register
//   addr_width() - register address width for a given register count
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned REG_ZERO  = 0;

  // Never returns 0 so a one-register file still has a legal address bus.
  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/rf_wr_select.sv
// Priority match of all write ports against one register address.
//   addr    in  AW           address being matched
//   wr_en   in  NWRITE       write enables
//   wr_addr in  NWRITE*AW    write addresses, port w at [w*AW +: AW]
//   wr_data in  NWRITE*XLEN  write data, port w at [w*XLEN +: XLEN]
//   hit     out 1            some enabled port targets addr
//   data    out XLEN         data of the highest-index matching port
//   multi   out 1            two or more enabled ports target addr
module rf_wr_select #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned AW     = 5,
  parameter int unsigned NWRITE = 2
) (
  input  logic [AW-1:0]          addr,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  output logic                   hit,
  output logic [XLEN-1:0]        data,
  output logic                   multi
);

  // Ascending scan: later (higher-index) matches override earlier ones.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    multi = 1'b0;
    for (int w = 0; w < int'(NWRITE); w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
        if (hit) multi = 1'b1;
        hit  = 1'b1;
        data = wr_data[w*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
//   clk        in  1            rising-edge clock
//   reset      in  1            asynchronous active-high reset
//   rd_addr    in  NREAD*AW     read addresses
//   rd_data    out NREAD*XLEN   combinational read data
//   rd_busy    out NREAD        scoreboard bit of each read address
//   wr_en      in  NWRITE       write enables (higher index wins)
//   wr_addr    in  NWRITE*AW    write addresses
//   wr_data    in  NWRITE*XLEN  write data
//   alloc_en   in  1            mark alloc_addr busy
//   alloc_addr in  AW           destination register being allocated
//   busy_vec   out NREGS        full scoreboard
//   conflict   out 1            previous cycle had a same-address multi-write
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NREAD  = 2,
  parameter  int unsigned NWRITE = 2,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = addr_width(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  output logic [NREGS-1:0]       busy_vec,
  output logic                   conflict
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             conflict_q, conflict_d;

  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] wr_multi;
  logic [XLEN-1:0]  wr_sel_data [NREGS];

  // Per-register write decode; register 0 is never a write target.
  for (genvar r = 0; r < int'(NREGS); r++) begin : g_wr
    if (r == int'(REG_ZERO)) begin : g_zero
      assign wr_hit[r]      = 1'b0;
      assign wr_multi[r]    = 1'b0;
      assign wr_sel_data[r] = '0;
    end else begin : g_reg
      rf_wr_select #(
        .XLEN   (XLEN),
        .AW     (AW),
        .NWRITE (NWRITE)
      ) u_sel (
        .addr    (AW'(r)),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .hit     (wr_hit[r]),
        .data    (wr_sel_data[r]),
        .multi   (wr_multi[r])
      );
    end
  end

  // Only real nonzero registers contribute, so x0 and out-of-range collisions never flag.
  assign conflict_d = |wr_multi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < int'(NREGS); r++) begin
        if (wr_hit[r]) regs_q[r] <= wr_sel_data[r];
      end
    end
  end

  // Alloc beats a same-cycle writeback: it names a newer producer.
  always_comb begin
    busy_d           = busy_q;
    busy_d[REG_ZERO] = 1'b0;
    for (int r = 1; r < int'(NREGS); r++) begin
      if (alloc_en && (alloc_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_vec = busy_q;
  assign conflict = conflict_q;

  for (genvar p = 0; p < int'(NREAD); p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            match;
    logic [XLEN-1:0] stored;
    logic            stored_busy;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;
    logic            byp_multi_unused;
    logic            fwd;

    assign addr = rd_addr[p*AW +: AW];

    // match stays 0 for x0 and out-of-range addresses, which read as 0 / not busy.
    always_comb begin
      match       = 1'b0;
      stored      = '0;
      stored_busy = 1'b0;
      for (int r = 1; r < int'(NREGS); r++) begin
        if (addr == AW'(r)) begin
          match       = 1'b1;
          stored      = regs_q[r];
          stored_busy = busy_q[r];
        end
      end
    end

    rf_wr_select #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_byp (
      .addr    (addr),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (byp_hit),
      .data    (byp_data),
      .multi   (byp_multi_unused)
    );

    assign fwd = (BYPASS != 0) && match && byp_hit;

    assign rd_data[p*XLEN +: XLEN] = reset ? '0 : (fwd ? byp_data : stored);
    assign rd_busy[p]              = !reset && stored_busy && !fwd;
  end

endmodule
